fixed_block_accumulator: RTL and testbench
==========================================

Name: fixed_block_accumulator

Overview:
- Streaming signed fixed-point accumulator. Sums each group of BLOCK_SIZE consecutive input beats into one full-precision sum.
- Sits directly upstream of the signed fixed-point cast/clamp stage, which narrows the wide sum back to the datapath width.
- Valid/ready handshake on both sides. Output is registered.

Parameters:
- IN_WIDTH, 8, total bits of the signed input
- IN_FRAC_WIDTH, 4, fractional bits of the input; the output keeps the same fraction width
- BLOCK_SIZE, 4, beats per sum; must be >= 1
- OUT_WIDTH, IN_WIDTH + $clog2(BLOCK_SIZE), width of the sum; derived localparam, not overridable

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_in  in  IN_WIDTH  signed input sample
- data_in_valid  in  1  input beat valid
- data_in_ready  out  1  block can accept a beat
- data_out  out  OUT_WIDTH  signed block sum, fraction width IN_FRAC_WIDTH
- data_out_valid  out  1  sum held in the output register
- data_out_ready  in  1  downstream accepts the sum

Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset values:
  - acc = 0, count = 0
  - data_out = 0, data_out_valid = 0
  - data_in_ready = 1 on the first cycle after reset deasserts
- Input acceptance: a beat is accepted when data_in_valid && data_in_ready.
- Arithmetic:
  - data_in is sign-extended to OUT_WIDTH before adding.
  - No rounding or saturation. OUT_WIDTH is exact, so overflow is impossible by construction.
- Counter: count runs 0..BLOCK_SIZE-1.
  - Accepted beat with count < BLOCK_SIZE-1: acc <= acc + in, count++.
  - Accepted beat with count == BLOCK_SIZE-1 (the "closing beat"): data_out <= acc + in, data_out_valid <= 1, acc <= 0, count <= 0.
- Latency: the sum appears on data_out one cycle after the closing beat is accepted.
- BLOCK_SIZE == 1: every beat is a closing beat, so data_out is the sign-extended input, 1-cycle latency.
- Backpressure:
  - out_free = !data_out_valid || data_out_ready.
  - data_in_ready = (count != BLOCK_SIZE-1) || out_free.
  - Non-closing beats keep flowing while a sum waits downstream. Only the closing beat stalls.
- Drain: when data_out_valid && data_out_ready and no closing beat is accepted that cycle, data_out_valid <= 0. data_out is unchanged.
- Simultaneous drain and closing beat: the new sum loads and data_out_valid stays 1. This gives full throughput of 1 sum per BLOCK_SIZE cycles with no bubble.
- Output stability: while data_out_valid && !data_out_ready, data_out is held stable.
- No combinational path from data_in_valid to data_in_ready. The path from data_out_ready to data_in_ready is combinational.
- Reset mid-block: a partial acc is discarded and a pending output is dropped. The next block starts clean at count 0.
- Input X while data_in_valid = 0 must not propagate into acc.

Optional Feature:
- Macro: FIXED_BLOCK_ACCUMULATOR_FLUSH_EN.
- Defined:
  - Adds input port data_in_last (1 bit).
  - An accepted beat with data_in_last = 1 is treated as a closing beat regardless of count. The partial sum loads to the output and count resets to 0.
  - data_in_ready uses (count != BLOCK_SIZE-1 && !data_in_last) in place of (count != BLOCK_SIZE-1).
  - Width is unchanged, since a partial block cannot exceed BLOCK_SIZE beats.
- Undefined: port absent; blocks close only on count.

Decomposition:
- Shared package fixed_accum_pkg:
  - function accum_width(in_w, n) returning in_w + $clog2(n)
  - typedef of the count type sized $clog2(BLOCK_SIZE) with a minimum of 1 bit
- One natural sub-module: fixed_accum_out_reg, the one-entry output holding register with valid/ready load/drain logic.
  - Reusable by other reduction stages feeding the cast stage.

Test Plan:
- Defaults. Feed 0x10, 0x10, 0x10, 0x10 (1.0 each) back-to-back with data_out_ready = 1 -> data_out = 10'h040 (4.0) with data_out_valid = 1 for exactly one cycle, one cycle after the 4th beat.
- Negative extremes. Feed 0x80 ×4 -> data_out = 10'h200 (-32.0). Then feed 0x7F ×4 -> 10'h1FC. No wrap.
- Backpressure. Hold data_out_ready = 0 after the first sum, stream 8 beats of 0x01 -> beats 5-7 accepted, 8th stalls (data_in_ready = 0), data_out stays 0x004. Release ready -> 8th beat accepted in the same cycle, data_out = 0x004 again, valid continuous.
- Reset mid-block. Accept 2 beats of 0x20, pulse rst, then 4 beats of 0x01 -> data_out = 0x004. No residue from before reset.
- BLOCK_SIZE = 1, IN_WIDTH = 8. Feed 0xF0 -> data_out = 8'hF0 one cycle later.
- FLUSH_EN. Feed 0x10, then 0x10 with data_in_last = 1 -> data_out = 0x020, count returns to 0. The next full block of 0x01 ×4 gives 0x004.

Source files
------------

// File: rtl/fixed_accum_pkg.sv
// -----------------------------------------------------------------------------
// fixed_accum_pkg
//
// Shared helpers for the fixed-point reduction stages that feed the
// signed cast/clamp stage.
//
//   accum_width(in_w, n) : exact width of a sum of n signed in_w-bit values.
//                          The result can never overflow.
//   count_width(n)       : width of a 0..n-1 beat counter, at least 1 bit.
//   count_t              : beat counter type for the default block size of 4.
//                          Modules with another block size declare their own
//                          counter type with count_width().
// -----------------------------------------------------------------------------
package fixed_accum_pkg;

    // Bits needed to hold the sum of n signed values of in_w bits each.
    function automatic int accum_width(input int in_w, input int n);
        return in_w + $clog2(n);
    endfunction

    // Counter width for 0..n-1. A one-beat block still gets a 1-bit counter.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_BLOCK_SIZE = 4;

    typedef logic [count_width(DEFAULT_BLOCK_SIZE)-1:0] count_t;

endpackage : fixed_accum_pkg

// File: rtl/fixed_block_accumulator_if.sv
// -----------------------------------------------------------------------------
// fixed_block_accumulator_if
//
// Bundles both valid/ready streams of the block accumulator.
//   data_in / data_in_valid / data_in_ready      : input sample stream
//   data_in_last                                 : early block close. Present
//                                                  only when
//                                                  FIXED_BLOCK_ACCUMULATOR_FLUSH_EN
//                                                  is defined.
//   data_out / data_out_valid / data_out_ready   : block-sum stream
//
// Modports:
//   slave  : the accumulator. It consumes samples and produces sums.
//   master : the environment. It produces samples and consumes sums.
// -----------------------------------------------------------------------------
interface fixed_block_accumulator_if #(
    parameter int IN_WIDTH   = 8,
    parameter int BLOCK_SIZE = 4
) ();
    import fixed_accum_pkg::*;

    localparam int OUT_WIDTH = accum_width(IN_WIDTH, BLOCK_SIZE);

    logic [IN_WIDTH-1:0]  data_in;
    logic                 data_in_valid;
    logic                 data_in_ready;
`ifdef FIXED_BLOCK_ACCUMULATOR_FLUSH_EN
    logic                 data_in_last;
`endif
    logic [OUT_WIDTH-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;

    modport slave (
`ifdef FIXED_BLOCK_ACCUMULATOR_FLUSH_EN
        input  data_in_last,
`endif
        input  data_in,
        input  data_in_valid,
        output data_in_ready,
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport master (
`ifdef FIXED_BLOCK_ACCUMULATOR_FLUSH_EN
        output data_in_last,
`endif
        output data_in,
        output data_in_valid,
        input  data_in_ready,
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );

endinterface : fixed_block_accumulator_if

// File: rtl/fixed_accum_out_reg.sv
// -----------------------------------------------------------------------------
// fixed_accum_out_reg
//
// One-entry output holding register with a valid/ready drain. Reduction
// stages feeding the cast stage use it to present a registered result.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : load i_data this cycle. The caller asserts it only when
//               o_free is high.
//   i_data    : value to load
//   i_ready   : downstream accepts o_data this cycle
//   o_data    : held value. It stays stable while o_valid && !i_ready and
//               is unchanged after a drain.
//   o_valid   : o_data holds a value not yet taken downstream
//   o_free    : a load this cycle loses nothing (empty, or draining now).
//               This is combinational from i_ready.
// -----------------------------------------------------------------------------
module fixed_accum_out_reg #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_free
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    assign o_free  = !r_valid || i_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    // Load has priority over drain, so a load and a drain in the same cycle keep valid high with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_data  <= r_data;
            r_valid <= r_valid;
        end
    end

endmodule : fixed_accum_out_reg

// File: rtl/fixed_block_accumulator.sv
// -----------------------------------------------------------------------------
// fixed_block_accumulator
//
// Streaming signed fixed-point accumulator. Each group of BLOCK_SIZE accepted
// beats is summed at full precision into OUT_WIDTH = IN_WIDTH +
// $clog2(BLOCK_SIZE) bits. The fraction width (IN_FRAC_WIDTH) is unchanged.
// The sum is registered and appears one cycle after the closing beat.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset. It drops any partial sum and any
//          pending output.
//   bus  : fixed_block_accumulator_if.slave (input samples in, block sums out)
//
// Optional feature: define FIXED_BLOCK_ACCUMULATOR_FLUSH_EN to add
// bus.data_in_last. An accepted beat with data_in_last set closes the block
// early.
//
// data_in_ready depends combinationally on data_out_ready, and on
// data_in_last when that port exists. It never depends on data_in_valid.
// -----------------------------------------------------------------------------
module fixed_block_accumulator
    import fixed_accum_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int IN_FRAC_WIDTH = 4,
    parameter int BLOCK_SIZE    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    fixed_block_accumulator_if.slave   bus
);

    localparam int OUT_WIDTH = accum_width(IN_WIDTH, BLOCK_SIZE);
    localparam int CNT_WIDTH = count_width(BLOCK_SIZE);

    typedef logic [CNT_WIDTH-1:0] blk_count_t;

    localparam blk_count_t CNT_LAST = blk_count_t'(BLOCK_SIZE - 1);

    // Reject configurations with no valid meaning at elaboration time.
    if (BLOCK_SIZE < 1 || IN_FRAC_WIDTH < 0 || IN_FRAC_WIDTH > IN_WIDTH) begin : g_param_check
        $error("fixed_block_accumulator: BLOCK_SIZE must be >= 1 and 0 <= IN_FRAC_WIDTH <= IN_WIDTH");
    end

    logic signed [OUT_WIDTH-1:0] r_acc;
    blk_count_t                  r_count;

    logic signed [OUT_WIDTH-1:0] w_in_ext;
    logic signed [OUT_WIDTH-1:0] w_sum;
    logic                        w_close_cond;
    logic                        w_in_ready;
    logic                        w_accept;
    logic                        w_closing;
    logic                        w_out_free;
    logic [OUT_WIDTH-1:0]        w_out_data;
    logic                        w_out_valid;

    // The sign-extending size cast keeps the binary point fixed.
    assign w_in_ext = OUT_WIDTH'($signed(bus.data_in));
    assign w_sum    = r_acc + w_in_ext;

    // Closing-beat detection and the input handshake.
    always_comb begin
        w_close_cond = 1'b0;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_closing    = 1'b0;
`ifdef FIXED_BLOCK_ACCUMULATOR_FLUSH_EN
        w_close_cond = (r_count == CNT_LAST) || bus.data_in_last;
`else
        w_close_cond = (r_count == CNT_LAST);
`endif
        // Only a closing beat needs space downstream. Other beats keep flowing during a stall.
        w_in_ready   = !w_close_cond || w_out_free;
        w_accept     = bus.data_in_valid && w_in_ready;
        w_closing    = w_accept && w_close_cond;
    end

    // Running partial sum and beat counter. Both change only on an accepted beat, so data_in is ignored when not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_closing) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= r_count + blk_count_t'(1'b1);
        end else begin
            r_acc   <= r_acc;
            r_count <= r_count;
        end
    end

    fixed_accum_out_reg #(
        .WIDTH (OUT_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_closing),
        .i_data  (w_sum),
        .i_ready (bus.data_out_ready),
        .o_data  (w_out_data),
        .o_valid (w_out_valid),
        .o_free  (w_out_free)
    );

    assign bus.data_in_ready  = w_in_ready;
    assign bus.data_out       = w_out_data;
    assign bus.data_out_valid = w_out_valid;

endmodule : fixed_block_accumulator

// File: tb/tb_fixed_block_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fixed_block_accumulator
//
// Scoreboard bench. Drivers push accepted beats into a reference model built
// from queues. A closed block pushes its integer sum to an expected queue. A
// monitor on the falling edge pops that queue whenever a sum is handed
// downstream. A second instance checks BLOCK_SIZE = 1.
// -----------------------------------------------------------------------------
module tb_fixed_block_accumulator;

    localparam int IN_W = 8;
    localparam int BS   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fixed_block_accumulator_if #(.IN_WIDTH(IN_W), .BLOCK_SIZE(BS)) bus  ();
    fixed_block_accumulator_if #(.IN_WIDTH(IN_W), .BLOCK_SIZE(1))  bus1 ();

    fixed_block_accumulator #(.IN_WIDTH(IN_W), .IN_FRAC_WIDTH(4), .BLOCK_SIZE(BS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fixed_block_accumulator #(.IN_WIDTH(IN_W), .IN_FRAC_WIDTH(4), .BLOCK_SIZE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_mode = 0;       // 0: always ready, 1: never ready, 2: random
    bit done1 = 1'b0;

    // Reference model state for the BLOCK_SIZE = 4 instance
    int part[$];            // signed beats of the current block
    int expq[$];            // sums loaded or about to load, not yet drained
    int hold_v = 0;         // value data_out must show when nothing is pending

    // Reference model state for the BLOCK_SIZE = 1 instance
    int q1[$];
    int hold1 = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d (0x%0h) expected=%0d (0x%0h) @%0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Monitor and scoreboard for the main instance
    always @(negedge clk) begin
        if (rst) begin
            part.delete();
            expq.delete();
            hold_v = 0;
        end else begin
            bit close_cond;
            int s;
`ifdef FIXED_BLOCK_ACCUMULATOR_FLUSH_EN
            close_cond = (part.size() == BS - 1) || bus.data_in_last;
`else
            close_cond = (part.size() == BS - 1);
`endif
            check("out_valid", longint'(bus.data_out_valid), longint'(expq.size() != 0));
            check("out_data", longint'($signed(bus.data_out)),
                  longint'((expq.size() != 0) ? expq[0] : hold_v));
            check("in_ready", longint'(bus.data_in_ready),
                  longint'(!close_cond || (expq.size() == 0) || bus.data_out_ready));
            if (bus.data_out_valid && bus.data_out_ready && expq.size() != 0)
                hold_v = expq.pop_front();
            if (bus.data_in_valid && bus.data_in_ready) begin
                part.push_back(int'($signed(bus.data_in)));
                if (close_cond) begin
                    s = 0;
                    foreach (part[k]) s += part[k];
                    expq.push_back(s);
                    part.delete();
                end
            end
        end
    end

    // Monitor and scoreboard for the one-beat-block instance
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            hold1 = 0;
        end else begin
            check("bs1_valid", longint'(bus1.data_out_valid), longint'(q1.size() != 0));
            check("bs1_data", longint'($signed(bus1.data_out)),
                  longint'((q1.size() != 0) ? q1[0] : hold1));
            check("bs1_ready", longint'(bus1.data_in_ready),
                  longint'((q1.size() == 0) || bus1.data_out_ready));
            if (bus1.data_out_valid && bus1.data_out_ready && q1.size() != 0)
                hold1 = q1.pop_front();
            if (bus1.data_in_valid && bus1.data_in_ready)
                q1.push_back(int'($signed(bus1.data_in)));
        end
    end

    // Downstream ready driver for the main instance
    initial begin
        bus.data_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.data_out_ready = 1'b1;
                1:       bus.data_out_ready = 1'b0;
                default: bus.data_out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic set_last(input logic l);
`ifdef FIXED_BLOCK_ACCUMULATOR_FLUSH_EN
        bus.data_in_last = l;
`else
        if (l) bus.data_in_valid = bus.data_in_valid;
`endif
    endtask

    // Drive one beat and hold it until accepted, with a bounded wait.
    task automatic send(input logic [7:0] d, input logic l);
        int  n;
        bit  took;
        n    = 0;
        took = 1'b0;
        bus.data_in       = d;
        bus.data_in_valid = 1'b1;
        set_last(l);
        while (!took && n < 100) begin
            @(negedge clk);
            took = bus.data_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("send_accepted", longint'(took), 64'sd1);
    endtask

    task automatic idle();
        bus.data_in_valid = 1'b0;
        bus.data_in       = 8'($urandom);
        set_last(1'($urandom_range(0, 1)));
    endtask

    // Four back-to-back beats of one value, then check the registered sum.
    task automatic block4(input logic [7:0] d, input logic [9:0] exp, input string nm);
        repeat (4) send(d, 1'b0);
        idle();
        @(negedge clk);
        check(nm, longint'(bus.data_out), longint'(exp));
        check({nm, "_valid"}, longint'(bus.data_out_valid), 64'sd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Main stimulus
    initial begin
        bus.data_in       = 8'h00;
        bus.data_in_valid = 1'b0;
        set_last(1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic block: 4 x 1.0 = 4.0. Valid lasts one cycle because ready is high.
        block4(8'h10, 10'h040, "sum_ones");
        check("sum_ones_one_cycle", longint'(bus.data_out_valid), 64'sd0);

        // Negative and positive extremes, no wrap
        block4(8'h80, 10'h200, "sum_min");
        block4(8'h7F, 10'h1FC, "sum_max");

        // Backpressure: a sum waits and non-closing beats keep flowing
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        repeat (7) send(8'h01, 1'b0);
        bus.data_in       = 8'h01;
        bus.data_in_valid = 1'b1;
        set_last(1'b0);
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_ready", longint'(bus.data_in_ready), 64'sd0);
            check("bp_hold_data", longint'(bus.data_out), longint'(10'h004));
        end
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(8'h01, 1'b0);
        idle();
        @(negedge clk);
        check("bp_reload_data", longint'(bus.data_out), longint'(10'h004));
        check("bp_reload_valid", longint'(bus.data_out_valid), 64'sd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a block leaves no residue
        send(8'h20, 1'b0);
        send(8'h20, 1'b0);
        idle();
        pulse_reset();
        block4(8'h01, 10'h004, "post_reset");

        // Randomized traffic with random backpressure and idle gaps
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                send(8'($urandom), 1'($urandom_range(0, 5) == 0));
            end else begin
                idle();
                @(posedge clk);
                #1;
            end
        end
        idle();

`ifdef FIXED_BLOCK_ACCUMULATOR_FLUSH_EN
        // Early close with data_in_last, then a normal full block
        rdy_mode = 0;
        pulse_reset();
        send(8'h10, 1'b0);
        send(8'h10, 1'b1);
        idle();
        set_last(1'b0);
        @(negedge clk);
        check("flush_sum", longint'(bus.data_out), longint'(10'h020));
        @(posedge clk);
        #1;
        block4(8'h01, 10'h004, "flush_next_block");
`endif

        rdy_mode = 0;
        repeat (6) @(posedge clk);
        for (int i = 0; i < 1000 && !done1; i++) @(posedge clk);
        check("bs1_finished", longint'(done1), 64'sd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Stimulus for the BLOCK_SIZE = 1 instance
    initial begin
        bus1.data_in        = 8'h00;
        bus1.data_in_valid  = 1'b0;
        bus1.data_out_ready = 1'b1;
`ifdef FIXED_BLOCK_ACCUMULATOR_FLUSH_EN
        bus1.data_in_last   = 1'b0;
`endif
        @(negedge rst);
        bus1.data_in       = 8'hF0;
        bus1.data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.data_in_valid = 1'b0;
        @(negedge clk);
        check("bs1_f0", longint'(bus1.data_out), longint'(8'hF0));
        repeat (300) begin
            @(posedge clk);
            #1;
            bus1.data_in        = 8'($urandom);
            bus1.data_in_valid  = 1'($urandom_range(0, 1));
            bus1.data_out_ready = 1'($urandom_range(0, 1));
`ifdef FIXED_BLOCK_ACCUMULATOR_FLUSH_EN
            bus1.data_in_last   = 1'($urandom_range(0, 1));
`endif
        end
        bus1.data_in_valid  = 1'b0;
        bus1.data_out_ready = 1'b1;
        done1 = 1'b1;
    end

endmodule : tb_fixed_block_accumulator
